core_seq_ctrl: RTL
==================

// Module: core_seq_ctrl
// PURPOSE
//   Multi-cycle sequencer for the RV32I core datapath (PC, ROM, decoder, register file, ALU, RAM).
//   Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and gates the PC, IR, register and RAM strobes.
//   Waits on a RAM acknowledge handshake with a timeout.
//   Provides run/halt/single-step debug control and a retired-instruction counter.
//   Replaces free-running single-cycle PC update; sits between Decoder_control outputs and the datapath enables.
// PARAMETERS
//   MEM_TIMEOUT  15  max MEM-state cycles without mem_ack before fault (>=1)
//   CNT_W        32  width of instret counter
// PORTS
//   clk          in   1      core clock; single clock domain
//   rst          in   1      synchronous reset, active-high
//   run_en       in   1      level: free-run instructions while high
//   step_req     in   1      pulse: execute exactly one instruction from HALT
//   halt_req     in   1      pulse: stop at next instruction boundary
//   dec_load     in   1      decoder: instruction is a load (sampled in DECODE)
//   dec_store    in   1      decoder: instruction is a store (sampled in DECODE)
//   dec_reg_wr   in   1      decoder: instruction writes rd (sampled in DECODE)
//   dec_illegal  in   1      decoder: unsupported opcode (sampled in DECODE)
//   mem_ack      in   1      RAM: access complete
//   ir_we        out  1      latch ROM output into instruction register
//   pc_we        out  1      load pc_new into PC
//   reg_we       out  1      register-file write enable
//   mem_rd       out  1      RAM read request, held until ack/timeout
//   mem_wr       out  1      RAM write request, held until ack/timeout
//   halted       out  1      FSM in HALT
//   fault        out  1      sticky: illegal instruction or MEM timeout
//   instret      out  CNT_W  retired-instruction count
//   state_o      out  3      current state encoding (debug)
// BEHAVIOUR
//   Reset (first edge with rst=1)
//     - state=HALT; halted=1; all strobes 0.
//     - fault=0; instret=0; halt_pend=0; step_flag=0; latched dec bits=0.
//     - Applies from any state, including mid-MEM.
//   Outputs: Moore, decoded from registered state only.
//   HALT
//     - fault=1: stay in HALT (cleared only by rst).
//     - Else run_en=1: ->FETCH.
//     - Else step_req=1: ->FETCH, step_flag=1.
//     - halt_req in HALT is ignored; halt_pend is cleared on HALT entry.
//   FETCH (1 cycle): ir_we=1 (ROM synchronous read); ->DECODE.
//   DECODE (1 cycle): latch dec_load/dec_store/dec_reg_wr.
//     - dec_illegal=1: fault<=1, ->HALT; no pc_we, no instret.
//     - Else ->EXEC.
//   EXEC (1 cycle, ALU settle)
//     - ->MEM if load or store.
//     - Else ->WB.
//   MEM
//     - mem_rd=load, mem_wr=store (store wins if both set).
//     - Wait counter starts at 0 on entry.
//     - mem_ack sampled high: ->WB (MEM lasts >=1 cycle).
//     - Counter reaches MEM_TIMEOUT with no ack: fault<=1, ->HALT, no retire.
//   WB (1 cycle)
//     - pc_we=1; reg_we=latched dec_reg_wr; instret<=instret+1, wraps modulo 2^CNT_W.
//     - Next: halt_pend|step_flag|!run_en ->HALT (step_flag cleared); else ->FETCH.
//   halt_req
//     - Pulse in any non-HALT state sets halt_pend.
//     - The current instruction completes.
//   Simultaneous events
//     - halt_req in WB: takes effect at that WB.
//     - fault and halt_req together: fault path wins.
//   Latency: non-memory instruction 4 cycles; memory instruction 4 + MEM cycles.
// STRUCTURE
//   Package core_ctrl_pkg:
//     - state encoding: HALT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
//     - STATE_W=3.
//   Sub-module mem_wdog: MEM wait counter.
//     - Ports: clk, rst, clr, en, expired.
//     - Counter width is $clog2(MEM_TIMEOUT+1).
//   Top: FSM, debug flags, instret register.
// TESTING
//   1 Reset behaviour
//     - rst=1 for 2 cycles, then run_en=1 with ALU instructions.
//     - halted=1 and instret=0 during reset.
//     - pc_we pulses every 4 cycles; instret=3 after 12 cycles.
//   2 Load with delayed ack
//     - Load with mem_ack on 3rd MEM cycle.
//     - mem_rd high exactly 3 cycles; WB reg_we=1; retires 7 cycles after FETCH.
//   3 Store timeout
//     - Store with mem_ack stuck 0, MEM_TIMEOUT=15.
//     - mem_wr high 15 cycles; then fault=1, halted=1, no pc_we, instret unchanged.
//   4 Illegal instruction
//     - dec_illegal=1.
//     - HALT 2 cycles after FETCH; fault=1 persists with run_en=1 until rst.
//   5 Halt and single-step
//     - halt_req pulse during EXEC with run_en=1: instruction completes (pc_we=1), then HALT.
//     - run_en=0, then step_req: instret +1 exactly, back to HALT.
//   6 Counter wrap
//     - CNT_W=4, run 16 ALU instructions.
//     - instret 15 -> 0; no fault.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared types for the multi-cycle core sequencer: state encoding and latched decode bits.
package core_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_HALT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    typedef struct packed {
        logic load;
        logic store;
        logic reg_wr;
    } dec_bits_t;

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Control/handshake bundle between the sequencer (master) and decoder/datapath/RAM (slave).
interface core_seq_ctrl_if
    import core_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic               run_en;
    logic               step_req;
    logic               halt_req;
    logic               dec_load;
    logic               dec_store;
    logic               dec_reg_wr;
    logic               dec_illegal;
    logic               mem_ack;
    logic               ir_we;
    logic               pc_we;
    logic               reg_we;
    logic               mem_rd;
    logic               mem_wr;
    logic               halted;
    logic               fault;
    logic [CNT_W-1:0]   instret;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  run_en, step_req, halt_req,
        input  dec_load, dec_store, dec_reg_wr, dec_illegal, mem_ack,
        output ir_we, pc_we, reg_we, mem_rd, mem_wr,
        output halted, fault, instret, state_o
    );

    modport slave (
        output run_en, step_req, halt_req,
        output dec_load, dec_store, dec_reg_wr, dec_illegal, mem_ack,
        input  ir_we, pc_we, reg_we, mem_rd, mem_wr,
        input  halted, fault, instret, state_o
    );
endinterface

// File: rtl/core_seq_ctrl_mem_wdog.sv
// MEM-state wait counter; expired is high during the last permitted MEM cycle.
module mem_wdog #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with run/halt/step debug
// control, RAM ack timeout and retired-instruction counter.
module core_seq_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    core_seq_ctrl_if.master  bus
);
    state_e          state_q, state_d;
    logic            fault_q, fault_d;
    logic            halt_pend_q, halt_pend_d;
    logic            step_flag_q, step_flag_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    dec_bits_t       dec_q, dec_d;
    logic            wdog_expired;

    mem_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q != ST_MEM),
        .en      (state_q == ST_MEM),
        .expired (wdog_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HALT;
            fault_q     <= 1'b0;
            halt_pend_q <= 1'b0;
            step_flag_q <= 1'b0;
            instret_q   <= '0;
            dec_q       <= '0;
        end else begin
            state_q     <= state_d;
            fault_q     <= fault_d;
            halt_pend_q <= halt_pend_d;
            step_flag_q <= step_flag_d;
            instret_q   <= instret_d;
            dec_q       <= dec_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        halt_pend_d = halt_pend_q;
        step_flag_d = step_flag_q;
        instret_d   = instret_q;
        dec_d       = dec_q;

        if (state_q != ST_HALT && bus.halt_req) begin
            halt_pend_d = 1'b1;
        end

        case (state_q)
            ST_HALT: begin
                if (!fault_q) begin
                    if (bus.run_en) begin
                        state_d = ST_FETCH;
                    end else if (bus.step_req) begin
                        state_d     = ST_FETCH;
                        step_flag_d = 1'b1;
                    end
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                dec_d.load   = bus.dec_load;
                dec_d.store  = bus.dec_store;
                dec_d.reg_wr = bus.dec_reg_wr;
                if (bus.dec_illegal) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = (dec_q.load || dec_q.store) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (bus.mem_ack) begin
                    state_d = ST_WB;
                end else if (wdog_expired) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_WB: begin
                instret_d = instret_q + CNT_W'(1);
                if (halt_pend_q || bus.halt_req || step_flag_q || !bus.run_en) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_HALT;
        endcase

        // Debug flags never survive into HALT, whichever path got us there.
        if (state_d == ST_HALT) begin
            halt_pend_d = 1'b0;
            step_flag_d = 1'b0;
        end
    end

    assign bus.ir_we   = (state_q == ST_FETCH);
    assign bus.pc_we   = (state_q == ST_WB);
    assign bus.reg_we  = (state_q == ST_WB) && dec_q.reg_wr;
    assign bus.mem_wr  = (state_q == ST_MEM) && dec_q.store;
    assign bus.mem_rd  = (state_q == ST_MEM) && dec_q.load && !dec_q.store;
    assign bus.halted  = (state_q == ST_HALT);
    assign bus.fault   = fault_q;
    assign bus.instret = instret_q;
    assign bus.state_o = state_q;
endmodule
